// File: rtl/traffic_conflict_monitor_if.sv
// -----------------------------------------------------------------------------
// traffic_conflict_monitor_if
// Light bus between the traffic controller (driver) and anything that watches
// its lamp outputs. Each light is a 2-bit colour:
//   00 RED, 01 YELLOW, 10 GREEN, 11 invalid.
// Signals: N_forward, N_left, S_forward, S_left, E_forward, E_left,
//          W_forward, W_left (2 bits each).
// Modports: master drives the lights, slave observes them.
// -----------------------------------------------------------------------------
interface traffic_conflict_monitor_if;
    logic [1:0] N_forward;
    logic [1:0] N_left;
    logic [1:0] S_forward;
    logic [1:0] S_left;
    logic [1:0] E_forward;
    logic [1:0] E_left;
    logic [1:0] W_forward;
    logic [1:0] W_left;

    modport master (
        output N_forward, N_left, S_forward, S_left,
        output E_forward, E_left, W_forward, W_left
    );

    modport slave (
        input N_forward, N_left, S_forward, S_left,
        input E_forward, E_left, W_forward, W_left
    );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// -----------------------------------------------------------------------------
// traffic_conflict_monitor
// Passive safety monitor on the traffic controller light bus. Every clock it
// samples all eight lights and flags, in priority order:
//   1 INVALID       a light shows 11
//   2 CONFLICT      active (non-red) lights in two or more groups
//   3 SEQUENCE      G->R, Y->G or R->Y (not checked on first sample after reset)
//   4 SHORT_YELLOW  Y->R after fewer than MIN_YELLOW yellow samples
//   5 STALL         more than MAX_ALLRED consecutive all-red samples
// The first fault is latched (code, light index, optional time stamp) until
// clr_fault; err_count counts violating cycles and saturates at 255.
//
// Optional feature: define MON_TIMESTAMP_EN to add a 16-bit free-running cycle
// counter whose value at the first violating sample is captured in fault_time.
// Without it fault_time is tied to 0.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   lights      in   light bus (slave modport)
//   clr_fault   in   synchronous pulse, clears the sticky fault record
//   fault       out  sticky fault flag
//   fault_code  out  first-fault code (0 = none)
//   fault_idx   out  first-fault light index
//   err_count   out  violating cycles since reset, saturating
//   fault_time  out  cycle stamp of first fault
// -----------------------------------------------------------------------------
module traffic_conflict_monitor #(
    parameter int MIN_YELLOW = 3,
    parameter int MAX_ALLRED = 16,
    parameter int CNT_W      = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    traffic_conflict_monitor_if.slave    lights,
    input  logic                         clr_fault,
    output logic                         fault,
    output logic [2:0]                   fault_code,
    output logic [2:0]                   fault_idx,
    output logic [7:0]                   err_count,
    output logic [15:0]                  fault_time
);

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;
    localparam logic [1:0] INV = 2'b11;

    localparam logic [CNT_W-1:0] YEL_SAT   = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] ALLRED_LIM = CNT_W'(MAX_ALLRED);
    localparam logic [CNT_W-1:0] ALLRED_SAT = CNT_W'(MAX_ALLRED + 1);

    // Lowest set bit position; callers only use it when v != 0.
    function automatic logic [2:0] low_idx(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    logic [7:0][1:0]  cur;
    logic [7:0][1:0]  prev;
    logic             prev_valid;
    logic [CNT_W-1:0] ycnt [8];
    logic [CNT_W-1:0] allred_cnt;
    logic [15:0]      stamp;

    logic [7:0] inv_v, act_v, seq_v, short_v;
    logic [3:0] grp_act;
    logic       conflict, all_red, stall, violation;
    logic [2:0] code_new, idx_new;
    logic       latch_new;

    always_comb begin
        cur = {lights.W_left, lights.W_forward, lights.E_left, lights.E_forward,
               lights.S_left, lights.S_forward, lights.N_left, lights.N_forward};
    end

    // Per-light rule evaluation against the previous sample.
    always_comb begin
        inv_v   = '0;
        act_v   = '0;
        seq_v   = '0;
        short_v = '0;
        for (int i = 0; i < 8; i++) begin
            inv_v[i]   = (cur[i] == INV);
            act_v[i]   = (cur[i] != RED);
            seq_v[i]   = prev_valid &&
                         (((prev[i] == GRN) && (cur[i] == RED)) ||
                          ((prev[i] == YEL) && (cur[i] == GRN)) ||
                          ((prev[i] == RED) && (cur[i] == YEL)));
            short_v[i] = (prev[i] == YEL) && (cur[i] == RED) && (ycnt[i] < YEL_SAT);
        end
    end

    always_comb begin
        // Groups: NSF {0,2}, NSL {1,3}, EWF {4,6}, EWL {5,7}.
        grp_act  = {act_v[5] | act_v[7], act_v[4] | act_v[6],
                    act_v[1] | act_v[3], act_v[0] | act_v[2]};
        // Two or more bits set <=> clearing the lowest set bit leaves something.
        conflict = ((grp_act & (grp_act - 4'd1)) != 4'd0);
        all_red  = (act_v == 8'd0);
        // allred_cnt holds the run length before this sample.
        stall    = all_red && (allred_cnt >= ALLRED_LIM);

        code_new = 3'd0;
        idx_new  = 3'd0;
        if (inv_v != 8'd0) begin
            code_new = 3'd1;
            idx_new  = low_idx(inv_v);
        end else if (conflict) begin
            code_new = 3'd2;
            idx_new  = low_idx(act_v);
        end else if (seq_v != 8'd0) begin
            code_new = 3'd3;
            idx_new  = low_idx(seq_v);
        end else if (short_v != 8'd0) begin
            code_new = 3'd4;
            idx_new  = low_idx(short_v);
        end else if (stall) begin
            code_new = 3'd5;
            idx_new  = 3'd0;
        end
        violation = (code_new != 3'd0);
        // A violation coinciding with clr_fault still gets recorded.
        latch_new = violation && (!fault || clr_fault);
    end

    // Monitoring state and fault record.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev       <= '0;
            prev_valid <= 1'b0;
            allred_cnt <= '0;
            for (int i = 0; i < 8; i++) ycnt[i] <= '0;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            fault_idx  <= 3'd0;
            err_count  <= 8'd0;
        end else begin
            prev       <= cur;
            prev_valid <= 1'b1;

            if (!all_red)                    allred_cnt <= '0;
            else if (allred_cnt != ALLRED_SAT) allred_cnt <= allred_cnt + 1'b1;

            for (int i = 0; i < 8; i++) begin
                if (cur[i] != YEL)          ycnt[i] <= '0;
                else if (ycnt[i] < YEL_SAT) ycnt[i] <= ycnt[i] + 1'b1;
            end

            if (violation && (err_count != 8'hFF)) err_count <= err_count + 8'd1;

            if (latch_new) begin
                fault      <= 1'b1;
                fault_code <= code_new;
                fault_idx  <= idx_new;
            end else if (clr_fault) begin
                fault      <= 1'b0;
                fault_code <= 3'd0;
                fault_idx  <= 3'd0;
            end
        end
    end

`ifdef MON_TIMESTAMP_EN
    logic [15:0] cycle_cnt;
    logic [15:0] fault_time_r;

    assign stamp      = cycle_cnt;
    assign fault_time = fault_time_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt    <= 16'd0;
            fault_time_r <= 16'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
            if (latch_new)      fault_time_r <= stamp;
            else if (clr_fault) fault_time_r <= 16'd0;
        end
    end
`else
    assign stamp      = 16'd0;
    assign fault_time = stamp;
`endif

endmodule
